// File: rtl/qep_pkg.sv
// Shared quadrature definitions: phase encodings, default widths and the
// Gray-sequence step helper used by both the emulator and the decoder.
package qep_pkg;
  localparam int QEP_PERIOD_W = 24;
  localparam int QEP_POS_W    = 32;

  // Encoding is {A,B} so the outputs come straight off the phase flops.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b10,
    S2 = 2'b11,
    S3 = 2'b01
  } qep_phase_e;

  function automatic qep_phase_e qep_step(input qep_phase_e ph, input logic fwd);
    qep_phase_e nx;
    case (ph)
      S0:      nx = fwd ? S1 : S3;
      S1:      nx = fwd ? S2 : S0;
      S2:      nx = fwd ? S3 : S1;
      default: nx = fwd ? S0 : S2;
    endcase
    return nx;
  endfunction
endpackage

// File: rtl/qep_rate_gen.sv
// Edge-rate generator: issues a one-cycle step every `period` clocks while enabled.
module qep_rate_gen
  import qep_pkg::*;
#(
  parameter int PERIOD_W = QEP_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                step
);
  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] tick_cnt;
  logic                run;

  assign run  = enable && (period != '0);
  // Compare with >= so a shortened period fires on the very next cycle.
  assign step = run && (tick_cnt >= period - ONE);

  always_ff @(posedge clk) begin
    if (rst)              tick_cnt <= '0;
    else if (!run || step) tick_cnt <= '0;
    else                  tick_cnt <= tick_cnt + ONE;
  end
endmodule

// File: rtl/qep_emulator.sv
// Quadrature encoder emulator: paced A/B Gray sequence with index pulse
// and a signed edge-position counter, all outputs registered.
module qep_emulator
  import qep_pkg::*;
#(
  parameter int PERIOD_W = QEP_PERIOD_W,
  parameter int POS_W    = QEP_POS_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] period,
  input  logic [POS_W-1:0]    counts_per_rev,
  input  logic                load,
  input  logic [POS_W-1:0]    load_value,
  output logic                qep_a,
  output logic                qep_b,
  output logic                qep_i,
  output logic [POS_W-1:0]    position,
  output logic                edge_strobe
);
  localparam logic [POS_W-1:0] ONE_P = POS_W'(1);

  qep_phase_e       phase, phase_nxt;
  logic [POS_W-1:0] rev_pos, rev_nxt;
  logic             step;
  logic             idx_en;

  // A load restarts the rate counter so the next step is a full period out.
  qep_rate_gen #(.PERIOD_W(PERIOD_W)) u_rate (
    .clk    (clk),
    .rst    (rst || load),
    .enable (enable),
    .period (period),
    .step   (step)
  );

  assign idx_en = (counts_per_rev != '0);

  always_ff @(posedge clk) begin
    if (rst) phase <= S0;
    else     phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    if (load)      phase_nxt = S0;
    else if (step) phase_nxt = qep_step(phase, dir);
  end

  always_comb begin
    qep_a = phase[1];
    qep_b = phase[0];
  end

  // rev_pos beyond a shrunken counts_per_rev snaps back to 0 going forward.
  always_comb begin
    rev_nxt = rev_pos;
    if (!idx_en)                               rev_nxt = '0;
    else if (dir)                              rev_nxt = (rev_pos >= counts_per_rev - ONE_P) ? '0 : rev_pos + ONE_P;
    else                                       rev_nxt = (rev_pos == '0) ? counts_per_rev - ONE_P : rev_pos - ONE_P;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      position    <= '0;
      rev_pos     <= '0;
      qep_i       <= 1'b0;
      edge_strobe <= 1'b0;
    end else if (load) begin
      position    <= load_value;
      rev_pos     <= '0;
      qep_i       <= idx_en;
      edge_strobe <= 1'b0;
    end else if (step) begin
      position    <= dir ? position + ONE_P : position - ONE_P;
      rev_pos     <= rev_nxt;
      qep_i       <= idx_en && (rev_nxt == '0);
      edge_strobe <= 1'b1;
    end else begin
      edge_strobe <= 1'b0;
    end
  end
endmodule

// File: tb/tb_qep_emulator.sv
// Scoreboard bench for qep_emulator: directed scenarios plus random traffic
// against a step-counting reference model.
module tb_qep_emulator;
  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        dir = 1'b1;
  logic [23:0] period = '0;
  logic [31:0] counts_per_rev = '0;
  logic        load = 1'b0;
  logic [31:0] load_value = '0;
  logic        qep_a, qep_b, qep_i, edge_strobe;
  logic [31:0] position;

  always #5 clk = ~clk;

  qep_emulator dut (
    .clk(clk), .rst(rst), .enable(enable), .dir(dir), .period(period),
    .counts_per_rev(counts_per_rev), .load(load), .load_value(load_value),
    .qep_a(qep_a), .qep_b(qep_b), .qep_i(qep_i), .position(position),
    .edge_strobe(edge_strobe)
  );

  typedef struct {
    int          cyc;
    logic [31:0] pos;
    logic [1:0]  ab;
    logic        i;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc_n = 0;

  // Reference model: phase index 0..3 into the {A,B} Gray table.
  logic [1:0]  ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int          m_el = 0;
  int          m_ph = 0;
  logic [31:0] m_pos = '0;
  longint      m_rev = 0;
  logic        m_i = 1'b0;
  logic        m_str = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic d, input int p,
                     input logic [31:0] c, input logic l, input logic [31:0] lv);
    exp_t x;
    longint cpr;
    @(negedge clk); #1;
    rst = r; enable = e; dir = d; period = p[23:0]; counts_per_rev = c;
    load = l; load_value = lv;
    cpr = longint'(c);
    if (r) begin
      m_el = 0; m_ph = 0; m_pos = '0; m_rev = 0; m_i = 1'b0; m_str = 1'b0;
    end else if (l) begin
      m_pos = lv; m_rev = 0; m_ph = 0; m_el = 0; m_i = (c != 0); m_str = 1'b0;
    end else if (e && p != 0) begin
      m_el++;
      m_str = 1'b0;
      if (m_el >= p) begin
        m_el = 0;
        m_str = 1'b1;
        m_ph = d ? (m_ph + 1) % 4 : (m_ph + 3) % 4;
        m_pos = d ? m_pos + 32'd1 : m_pos - 32'd1;
        if (cpr == 0)      m_rev = 0;
        else if (d)        m_rev = (m_rev + 1 >= cpr) ? 0 : m_rev + 1;
        else               m_rev = (m_rev == 0) ? cpr - 1 : m_rev - 1;
        m_i = (cpr != 0) && (m_rev == 0);
        x.cyc = cyc_n + 1; x.pos = m_pos; x.ab = ab_tab[m_ph]; x.i = m_i;
        q.push_back(x);
      end
    end else begin
      m_el = 0; m_str = 1'b0;
    end
  endtask

  // Monitor: cycle-accurate state compare plus scoreboard pop on each strobe.
  always @(negedge clk) begin
    exp_t e;
    if (cyc_n > 0) begin
      chk("strobe", 64'(edge_strobe), 64'(m_str));
      chk("position", 64'(position), 64'(m_pos));
      chk("ab", 64'({qep_a, qep_b}), 64'(ab_tab[m_ph]));
      chk("index", 64'(qep_i), 64'(m_i));
      if (edge_strobe) begin
        if (q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_step: strobe at cycle %0d, none expected", cyc_n);
        end else begin
          e = q.pop_front();
          chk("step_cycle", 64'(cyc_n), 64'(e.cyc));
          chk("step_pos", 64'(position), 64'(e.pos));
          chk("step_ab", 64'({qep_a, qep_b}), 64'(e.ab));
          chk("step_idx", 64'(qep_i), 64'(e.i));
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc_n) begin
        e = q.pop_front();
        vectors++; miscompares++;
        $display("FAIL missing_step: got no strobe, expected one at cycle %0d", e.cyc);
      end
    end
  end

  initial begin
    logic r, e, d, l;
    int p;
    logic [31:0] c;
    // Reset
    repeat (3) cyc(1, 1, 1, 4, 0, 1, 32'h55);
    @(posedge clk); #1;
    chk("reset_outputs", 64'({qep_a, qep_b, qep_i, edge_strobe, position}), 64'd0);

    // Period 4 forward from reset
    repeat (17) cyc(0, 1, 1, 4, 0, 0, 0);
    @(posedge clk); #1;
    chk("p4_position", 64'(position), 64'd4);

    // Index pass: 20 forward then 20 reverse steps, cpr=8
    cyc(0, 1, 1, 2, 8, 1, 0);
    repeat (40) cyc(0, 1, 1, 2, 8, 0, 0);
    repeat (40) cyc(0, 1, 0, 2, 8, 0, 0);
    @(posedge clk); #1;
    chk("index_final_pos", 64'(position), 64'd0);

    // Underflow wrap
    cyc(0, 1, 0, 1, 0, 1, 0);
    repeat (3) cyc(0, 1, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    chk("wrap_pos", 64'(position), 64'hFFFF_FFFD);
    chk("wrap_ab", 64'({qep_a, qep_b}), 64'b10);

    // Period shortened mid-count
    cyc(0, 1, 1, 100, 0, 1, 0);
    repeat (51) cyc(0, 1, 1, 100, 0, 0, 0);
    repeat (10) cyc(0, 1, 1, 3, 0, 0, 0);

    // Load coincident with a pending step
    for (int k = 0; k < 12 && m_el != 4; k++) cyc(0, 1, 1, 5, 4, 0, 0);
    cyc(0, 1, 1, 5, 4, 1, 32'h1234);
    @(posedge clk); #1;
    chk("load_pos", 64'(position), 64'h1234);
    chk("load_ab", 64'({qep_a, qep_b}), 64'b00);
    chk("load_strobe", 64'(edge_strobe), 64'd0);
    chk("load_idx", 64'(qep_i), 64'd1);
    repeat (11) cyc(0, 1, 1, 5, 4, 0, 0);

    // Reset mid-run, then frozen with period=0 / enable=0
    cyc(1, 1, 1, 5, 4, 0, 0);
    @(posedge clk); #1;
    chk("midrst_outputs", 64'({qep_a, qep_b, qep_i, edge_strobe, position}), 64'd0);
    repeat (10) cyc(0, 1, 1, 0, 4, 0, 0);
    repeat (3) cyc(0, 1, 1, 2, 4, 0, 0);
    repeat (10) cyc(0, 0, 1, 2, 4, 0, 0);
    cyc(0, 0, 1, 2, 4, 1, 32'hABCD);
    repeat (6) cyc(0, 1, 0, 2, 4, 0, 0);

    // Random traffic
    r = 0; e = 1; d = 1; p = 3; c = 6; l = 0;
    for (int k = 0; k < 1500; k++) begin
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) p = $urandom_range(0, 6);
      if ($urandom_range(0, 39) == 0) e = ~e;
      if ($urandom_range(0, 14) == 0) d = ~d;
      if ($urandom_range(0, 59) == 0) c = 32'($urandom_range(0, 10));
      cyc(r, e, d, p, c, l, $urandom);
    end
    cyc(0, 0, 1, 0, c, 0, 0);
    @(negedge clk); #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending steps, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
